// File: rtl/imm_decode_pipe_pkg.sv
// Shared core package: instruction format codes and RV32I major opcodes.
// Used by the immediate decoder and by any control unit / ALU-source mux
// that needs to interpret the format code produced by imm_decode_pipe.
package imm_decode_pipe_pkg;

    // 4-bit format code carried on out_type
    typedef enum logic [3:0] {
        FMT_LOAD    = 4'd0,
        FMT_IMM     = 4'd1,
        FMT_STORE   = 4'd2,
        FMT_REG     = 4'd3,
        FMT_LUI     = 4'd4,
        FMT_AUIPC   = 4'd5,
        FMT_BRNCH   = 4'd6,
        FMT_JALR    = 4'd7,
        FMT_JAL     = 4'd8,
        FMT_ILLEGAL = 4'hF
    } fmt_t;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRNCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_decode_pipe_dec.sv
// imm_format_dec: purely combinational RV32I immediate decoder.
// Ports:
//   inst    [31:0]      instruction word
//   fmt     [3:0]       format code (FMT_* from the package, 4'hF if illegal)
//   imm     [XLEN-1:0]  sign-extended immediate (0 for reg and illegal)
//   illegal             unsupported encoding
module imm_format_dec
    import imm_decode_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [3:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Raw immediate fields in RV32I bit packing; the signed casts below
    // sign-extend each one from inst[31] up to XLEN.
    logic [11:0] i_field;
    logic [11:0] s_field;
    logic [12:0] b_field;
    logic [31:0] u_field;
    logic [20:0] j_field;

    assign i_field = inst[31:20];
    assign s_field = {inst[31:25], inst[11:7]};
    assign b_field = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_field = {inst[31:12], 12'b0};
    assign j_field = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Every legal opcode ends in 2'b11, so a full 7-bit match also rejects
    // compressed-space encodings.
    always_comb begin
        fmt     = FMT_ILLEGAL;
        imm     = '0;
        illegal = 1'b0;
        case (inst[6:0])
            OP_LOAD:  begin fmt = FMT_LOAD;  imm = XLEN'($signed(i_field)); end
            OP_IMM:   begin fmt = FMT_IMM;   imm = XLEN'($signed(i_field)); end
            OP_STORE: begin fmt = FMT_STORE; imm = XLEN'($signed(s_field)); end
            OP_REG:   begin fmt = FMT_REG;   imm = '0; end
            OP_LUI:   begin fmt = FMT_LUI;   imm = XLEN'($signed(u_field)); end
            OP_AUIPC: begin fmt = FMT_AUIPC; imm = XLEN'($signed(u_field)); end
            OP_BRNCH: begin fmt = FMT_BRNCH; imm = XLEN'($signed(b_field)); end
            OP_JALR:  begin fmt = FMT_JALR;  imm = XLEN'($signed(i_field)); end
            OP_JAL:   begin fmt = FMT_JAL;   imm = XLEN'($signed(j_field)); end
            default: begin
                fmt     = FMT_ILLEGAL;
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: decodes an RV32I instruction stream into format code and
// immediate, buffered by a main output register plus a one-entry skid
// register so that in_ready can be registered without losing throughput.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop every buffered entry (and a same-cycle accept)
//   in_valid/in_ready/in_inst  input handshake and instruction
//   out_valid/out_ready      output handshake
//   out_inst/out_type/out_imm/out_illegal  decoded entry at the head
//   illegal_cnt              saturating count of illegal words delivered
module imm_decode_pipe
    import imm_decode_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [3:0]       out_type,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [3:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t dec_entry;
    entry_t main_reg, main_next;
    entry_t skid_reg, skid_next;
    logic   main_valid_reg, main_valid_next;
    logic   skid_valid_reg, skid_valid_next;
    logic   in_ready_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic accept;
    logic drain;

    // Decode at the input so the registered entry is ready to present
    imm_format_dec #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .fmt     (dec_entry.fmt),
        .imm     (dec_entry.imm),
        .illegal (dec_entry.illegal)
    );
    assign dec_entry.inst = in_inst;

    assign accept = in_valid && in_ready_reg;
    assign drain  = main_valid_reg && out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            // Data is left in place; only the valid bits matter
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (drain || !main_valid_reg) begin
            if (skid_valid_reg) begin
                // Skid is older than any new word: it moves up first
                main_valid_next = 1'b1;
                main_next       = skid_reg;
                skid_valid_next = accept;
                if (accept) begin
                    skid_next = dec_entry;
                end
            end else begin
                main_valid_next = accept;
                if (accept) begin
                    main_next = dec_entry;
                end
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_next       = dec_entry;
        end
    end

    // Counts delivered illegal words, including a delivery in a flush cycle
    always_comb begin
        cnt_next = cnt_reg;
        if (drain && main_reg.illegal && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            cnt_reg        <= '0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= !skid_valid_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = main_valid_reg;
    assign out_inst    = main_reg.inst;
    assign out_type    = main_reg.fmt;
    assign out_imm     = main_reg.imm;
    assign out_illegal = main_reg.illegal;
    assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed testbench for imm_decode_pipe. Instance a: XLEN=32, CNT_W=2
// (decode, illegal counting, backpressure, flush, reset). Instance b:
// XLEN=64 (lui sign extension and a random-handshake stream against a
// reference queue).
module tb_imm_decode_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance a
    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_inst, a_out_inst, a_out_imm;
    logic [3:0]  a_out_type;
    logic        a_out_illegal;
    logic [1:0]  a_cnt;

    // Instance b
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_inst, b_out_inst;
    logic [63:0] b_out_imm;
    logic [3:0]  b_out_type;
    logic        b_out_illegal;
    logic [7:0]  b_cnt;

    imm_decode_pipe #(.XLEN(32), .CNT_W(2)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_inst(a_out_inst), .out_type(a_out_type), .out_imm(a_out_imm),
        .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
    );

    imm_decode_pipe #(.XLEN(64), .CNT_W(8)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_inst(b_out_inst), .out_type(b_out_type), .out_imm(b_out_imm),
        .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    // Reference decode for XLEN=64, written from the RV32I field layout
    function automatic exp_t ref_dec(input logic [31:0] i);
        exp_t e;
        e.inst = i;
        e.ill  = 1'b0;
        e.imm  = 64'd0;
        case (i[6:0])
            7'b0000011: begin e.fmt = 4'd0; e.imm = {{52{i[31]}}, i[31:20]}; end
            7'b0010011: begin e.fmt = 4'd1; e.imm = {{52{i[31]}}, i[31:20]}; end
            7'b0100011: begin e.fmt = 4'd2; e.imm = {{52{i[31]}}, i[31:25], i[11:7]}; end
            7'b0110011: begin e.fmt = 4'd3; end
            7'b0110111: begin e.fmt = 4'd4; e.imm = {{32{i[31]}}, i[31:12], 12'h000}; end
            7'b0010111: begin e.fmt = 4'd5; e.imm = {{32{i[31]}}, i[31:12], 12'h000}; end
            7'b1100011: begin e.fmt = 4'd6; e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'b1100111: begin e.fmt = 4'd7; e.imm = {{52{i[31]}}, i[31:20]}; end
            7'b1101111: begin e.fmt = 4'd8; e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            default:    begin e.fmt = 4'hF; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    logic [31:0] dv_inst [4] = '{32'hFFF00093, 32'h123452B7, 32'hFFDFF06F, 32'h0020A423};
    logic [3:0]  dv_type [4] = '{4'd1, 4'd4, 4'd8, 4'd2};
    logic [31:0] dv_imm  [4] = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h00000008};
    logic [6:0]  op_tab  [11] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011,
                                  7'b0110111, 7'b0010111, 7'b1100011, 7'b1100111,
                                  7'b1101111, 7'b0001011, 7'b0010000};

    exp_t        q[$];
    exp_t        e;
    logic [31:0] r, held;
    logic        stalled;
    int          sent, got, cyc;

    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_inst = '0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_inst = '0; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_out_type", a_out_type, 0);
        chk("rst_out_imm", a_out_imm, 0);
        chk("rst_out_inst", a_out_inst, 0);
        chk("rst_out_illegal", a_out_illegal, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Decode vectors, streamed back-to-back, one cycle latency
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_inst   = dv_inst[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("dec%0d_valid", i), a_out_valid, 1);
            chk($sformatf("dec%0d_inst", i), a_out_inst, dv_inst[i]);
            chk($sformatf("dec%0d_type", i), a_out_type, dv_type[i]);
            chk($sformatf("dec%0d_imm", i), a_out_imm, dv_imm[i]);
            chk($sformatf("dec%0d_illegal", i), a_out_illegal, 0);
            if (i < 3) a_in_inst = dv_inst[i + 1];
            else       a_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("dec_drained", a_out_valid, 0);

        // Five illegal words; counter saturates at 3
        a_in_valid = 1'b1;
        a_in_inst  = 32'h00000000;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("ill%0d_valid", i), a_out_valid, 1);
            chk($sformatf("ill%0d_flag", i), a_out_illegal, 1);
            chk($sformatf("ill%0d_type", i), a_out_type, 4'hF);
            chk($sformatf("ill%0d_imm", i), a_out_imm, 0);
            chk($sformatf("ill%0d_cnt", i), a_cnt, (i - 1 > 3) ? 3 : i - 1);
            if (i == 5) a_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("ill_cnt_final", a_cnt, 3);
        chk("ill_drained", a_out_valid, 0);

        // Backpressure: A then B with out_ready low for three edges
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_inst   = 32'h123452B7;
        @(negedge clk);
        chk("bp_a_valid", a_out_valid, 1);
        chk("bp_a_inst", a_out_inst, 32'h123452B7);
        chk("bp_ready_after_a", a_in_ready, 1);
        a_in_inst = 32'hFFF00093;
        @(negedge clk);
        chk("bp_ready_after_b", a_in_ready, 0);
        chk("bp_a_held", a_out_inst, 32'h123452B7);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_still_full", a_in_ready, 0);
        chk("bp_a_stable", a_out_inst, 32'h123452B7);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_valid", a_out_valid, 1);
        chk("bp_b_inst", a_out_inst, 32'hFFF00093);
        chk("bp_b_imm", a_out_imm, 32'hFFFFFFFF);
        chk("bp_ready_release", a_in_ready, 1);
        @(negedge clk);
        chk("bp_drained", a_out_valid, 0);

        // Flush with both entries full and a concurrent input
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_inst   = 32'h0020A423;
        @(negedge clk);
        a_in_inst = 32'hFFDFF06F;
        @(negedge clk);
        chk("fl_full", a_in_ready, 0);
        a_in_inst = 32'h00000000;
        a_flush   = 1'b1;
        @(negedge clk);
        chk("fl_out_valid", a_out_valid, 0);
        chk("fl_in_ready", a_in_ready, 1);
        chk("fl_cnt", a_cnt, 3);
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("fl_no_stale", a_out_valid, 0);

        // Reset mid-stall discards both entries
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_inst   = 32'h123452B7;
        @(negedge clk);
        a_in_inst = 32'hFFF00093;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_rst      = 1'b1;
        a_flush    = 1'b1;
        @(negedge clk);
        chk("rs_out_valid", a_out_valid, 0);
        chk("rs_in_ready", a_in_ready, 1);
        chk("rs_cnt", a_cnt, 0);
        chk("rs_out_inst", a_out_inst, 0);
        a_rst   = 1'b0;
        a_flush = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("rs_no_stale", a_out_valid, 0);

        // XLEN=64: lui sign extension
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_inst   = 32'h800000B7;
        @(negedge clk);
        chk("x64_lui_type", b_out_type, 4);
        chk("x64_lui_imm", b_out_imm, 64'hFFFFFFFF80000000);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("x64_drained", b_out_valid, 0);

        // XLEN=64: 100 words, random in_valid / out_ready, reference queue
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stalled) chk("str_stable", b_out_inst, held);
            b_out_ready = ($urandom_range(0, 3) != 0);
            if (b_out_valid && b_out_ready) begin
                if (q.size() == 0) begin
                    chk("str_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("str%0d_inst", got), b_out_inst, e.inst);
                    chk($sformatf("str%0d_type_ill", got), {b_out_type, b_out_illegal}, {e.fmt, e.ill});
                    chk($sformatf("str%0d_imm", got), b_out_imm, e.imm);
                end
                got++;
            end
            stalled = b_out_valid && !b_out_ready;
            held    = b_out_inst;
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
                r = $urandom();
                b_in_valid = 1'b1;
                b_in_inst  = {r[31:7], op_tab[$urandom_range(0, 10)]};
            end else begin
                b_in_valid = 1'b0;
            end
            if (b_in_valid && b_in_ready) begin
                q.push_back(ref_dec(b_in_inst));
                sent++;
            end
        end
        b_in_valid = 1'b0;
        chk("str_count", got, 100);
        chk("str_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the illegal-instruction counter width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port flush, input, 1: discards all buffered entries.
REQ-006 Ports in_valid (input, 1), in_ready (output, 1) and in_inst (input, 32) SHALL carry the instruction input handshake.
REQ-007 Ports out_valid (output, 1) and out_ready (input, 1) SHALL carry the output handshake.
REQ-008 Output data SHALL be out_inst (32, the instruction), out_type (4, the format code), out_imm (XLEN, the immediate) and out_illegal (1, an unsupported-encoding flag).
REQ-009 Port illegal_cnt, output, CNT_W: saturating count of illegal instructions delivered at the output.

Function
REQ-010 Format codes SHALL be: load=0, imm=1, store=2, reg=3, lui=4, auipc=5, brnch=6, jalr=7, jal=8.
REQ-011 in_inst[6:0] SHALL select the format: 0000011→0, 0010011→1, 0100011→2, 0110011→3, 0110111→4, 0010111→5, 1100011→6, 1100111→7, 1101111→8.
REQ-012 Any other opcode, or in_inst[1:0]≠11, SHALL set out_illegal=1, out_type=4'hF and out_imm=0.
REQ-013 Immediates SHALL follow RV32I I/S/B/U/J packing, sign-extended from inst[31] to XLEN.
REQ-014 For U formats (lui, auipc), out_imm SHALL be {inst[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-015 For the reg format, out_imm SHALL be 0 and out_illegal SHALL be 0.
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 Storage SHALL be a main output register plus a one-entry skid register.
REQ-018 Latency SHALL be 1 cycle: a word accepted in cycle N appears at the output in cycle N+1 when the main register is empty or drains in cycle N.
REQ-019 in_ready SHALL be registered and SHALL equal !skid_valid.
REQ-020 An accept while the main register holds data that is not draining SHALL write the skid register.
REQ-021 When the main register drains and the skid is valid, the skid SHALL move to main in the same cycle, and any simultaneous accept SHALL be written to the skid.
REQ-022 Order SHALL be strictly preserved, with no loss and no duplication.
REQ-023 Sustained throughput SHALL be 1 instruction per cycle while out_ready=1.
REQ-024 Output data SHALL remain stable while out_valid && !out_ready.
REQ-025 flush SHALL clear both valid bits at the next edge, and any input accepted in the same cycle SHALL be dropped.
REQ-026 flush SHALL NOT change illegal_cnt, except that an output transfer in the flush cycle still counts.
REQ-027 illegal_cnt SHALL increment on each output transfer with out_illegal=1 and saturate at 2^CNT_W−1.

Reset
REQ-028 On rst=1 at a clock edge: out_valid=0, skid valid=0, in_ready=1, illegal_cnt=0, out_type=0, out_imm=0, out_inst=0, out_illegal=0.
REQ-029 rst SHALL take priority over flush and over any handshake in the same cycle.
REQ-030 Reset mid-stall SHALL discard both entries.

Structure
REQ-031 Format-code constants and opcode constants SHALL live in the shared core package for reuse by the control unit and the ALU-source muxes.
REQ-032 One combinational sub-module, imm_format_dec, SHALL map inst to {type, imm, illegal} for parameter XLEN.
REQ-033 The skid/handshake logic SHALL reside in imm_decode_pipe.

Verification
REQ-034 Decode checks, XLEN=32, out_ready=1:
  - 0xFFF00093 → type 1, imm 0xFFFFFFFF, 1 cycle later.
  - 0x123452B7 → type 4, imm 0x12345000.
  - 0xFFDFF06F → type 8, imm 0xFFFFFFFC.
  - 0x0020A423 → type 2, imm 0x00000008.
REQ-035 Illegal input, XLEN=32, CNT_W=2: 0x00000000 presented 5 times → out_illegal=1, type 0xF, imm 0; illegal_cnt reads 1, 2, 3, 3, 3.
REQ-036 Backpressure: out_ready=0 for 3 cycles while A and B are sent → in_ready=0 after B; on release, A then B are delivered on consecutive cycles with no loss.
REQ-037 Flush with both entries full plus in_valid=1 → out_valid=0 and in_ready=1 next cycle; no stale word is ever delivered.
REQ-038 XLEN=64: lui 0x800000B7 → imm 0xFFFFFFFF80000000; a stream of 100 instructions with random out_ready → output matches a reference-model queue exactly.
